if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction fetch queue between the PC/instruction-ROM fetch stage and the ID stage. It captures each fetched (pc, instruction) pair in a small circular FIFO and presents the oldest entry to ID. It decouples fetch from decode stalls, back-pressures fetch through `fq_full`, and discards all queued instructions on a branch flush.

## Interface
- `DEPTH`, default 4: number of queue entries; must be a power of two and at least 2.
- `CNT_W`, default 3: width of `fq_count`; equals log2(`DEPTH`)+1.
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `stall`  input  6  stall vector from CTRL; bit 1 = IF stalled, bit 2 = ID stalled.
- `flush`  input  1  branch-taken flush from ID; discards all queue contents.
- `if_valid`  input  1  fetch stage presents a valid instruction this cycle.
- `if_pc`  input  32  address of the fetched instruction.
- `if_inst`  input  32  fetched instruction word.
- `id_valid`  output  1  the head entry is valid and presented to ID.
- `id_pc`  output  32  PC of the head entry; 0 when empty.
- `id_inst`  output  32  instruction of the head entry; 0 (NOP) when empty.
- `fq_full`  output  1  the queue holds `DEPTH` entries; fetch must hold its PC.
- `fq_count`  output  `CNT_W`  number of occupied entries.
- `fq_ovf`  output  1  sticky flag: a push was dropped because the queue was full.

## Operation
- **State:** storage array [`DEPTH`] of {pc, inst}, write pointer `wp`, read pointer `rp`, count `cnt`, and `ovf`. Both pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
- **push_req** = `if_valid` & ~`stall[1]`.
- **pop** = `id_valid` & ~`stall[2]`. ID consumes the head entry in this cycle.
- **push accepted** = push_req & (`cnt` < `DEPTH` | pop). A push into a full queue is accepted when a pop happens in the same cycle.
- **Accepted push:** write {`if_pc`, `if_inst`} at `wp`; `wp` <= `wp`+1.
- **Pop:** `rp` <= `rp`+1.
- **Count update:** `cnt` <= `cnt` + push − pop. A simultaneous push and pop leaves `cnt` unchanged.
- **Dropped push:** push_req & full & ~pop drops the instruction, sets `ovf` <= 1, and leaves all other state unchanged.
- **Flush priority:** `flush` has priority over everything. `wp`, `rp` and `cnt` all go to 0, and any same-cycle push or pop is discarded. Storage contents are not cleared.
- **Output derivation:**
  - `id_valid` = (`cnt` != 0).
  - `id_pc`/`id_inst` = storage[`rp`] when `id_valid`, else 0.
  - `fq_full` = (`cnt` == `DEPTH`).
  - `fq_count` = `cnt`.
  - All outputs are derived only from registered state; no input-to-output combinational path.
- **States (derived from `cnt`):**
  - EMPTY (0): push only → PARTIAL.
  - PARTIAL (1..`DEPTH`−1): push only → +1; pop only → −1.
  - FULL (`DEPTH`): pop → `DEPTH`−1; push with pop → stays FULL; push without pop → drop plus `ovf`.
  - Flush from any state → EMPTY.
- **Reset values:**
  - `wp`=`rp`=`cnt`=0, `ovf`=0.
  - Outputs: `id_valid`=0, `id_pc`=0, `id_inst`=0, `fq_full`=0, `fq_count`=0, `fq_ovf`=0.
  - Storage is not reset.

## Timing
- Write latency is 1 cycle. An instruction pushed at edge N appears on `id_*` after edge N when the queue was empty.
- Throughput is 1 push and 1 pop per cycle, sustained indefinitely with no bubbles.
- `fq_full` asserts in the cycle after the `DEPTH`-th accepted push. Fetch observes it one cycle late, so any push it issues in that window while the queue is full and not popping sets `ovf`. CTRL must therefore OR `fq_full` into `stall[1]`.
- `flush` takes effect at the same edge. `id_valid` is 0 in the following cycle unless a new push arrives in that later cycle.
- `rst` deassertion is synchronised externally. Asserting `rst` mid-operation clears the queue immediately, without waiting for a clock edge.
- `stall[2]` held high freezes the head entry; `id_pc`/`id_inst` stay stable for the whole duration.

## Test plan
- **Fill and drain:** after reset, push PCs 0x0, 0x4, 0x8, 0xC with `stall`=0 except `stall[2]`=1.
  - Required: `fq_count` steps 1..4, then `fq_full`=1 and `id_pc`=0x0.
  - Then release `stall[2]` with `if_valid`=0. Required: `id_pc` reads 0x0, 0x4, 0x8, 0xC on consecutive cycles, then `id_valid`=0.
- **Pointer wrap-around:** stream 12 pushes with PCs 0x100 upward in steps of 4, with continuous pop and no stalls.
  - Required: `id_pc` trails by one cycle, `fq_count` stays 1, and `ovf` stays 0.
- **Full with simultaneous push and pop:** with the queue full (heads 0x0..0xC), push 0x10 while popping.
  - Required: `fq_count` stays 4, `id_pc` becomes 0x4, and 0x10 drains last.
- **Overflow:** with the queue full and `stall[2]`=1, push 0x20.
  - Required: `fq_ovf`=1 from the next cycle, `fq_count`=4, and 0x20 never appears on `id_pc`.
- **Flush:** with 3 entries queued, assert `flush` together with `if_valid` (pc 0x40).
  - Required: next cycle `fq_count`=0, `id_valid`=0, `id_pc`=0. A push of 0x80 in the following cycle then appears alone.
- **Asynchronous reset mid-stream:** pulse `rst` low between clock edges with 2 entries queued.
  - Required: `id_valid`=0, `fq_count`=0 and `fq_ovf`=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: a circular FIFO of (pc, inst) pairs between IF and ID.
// It absorbs decode stalls, back-pressures fetch via fq_full, and empties on a branch flush.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic             fq_full,
    output logic [CNT_W-1:0] fq_count,
    output logic             fq_ovf
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic push_req;
    logic pop;
    logic push_acc;
    logic wr_en;

    // Only the IF and ID stall bits matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[0]};

    assign push_req = if_valid & ~stall[1];
    assign pop      = id_valid & ~stall[2];
    assign push_acc = push_req & (~fq_full | pop);
    assign wr_en    = push_acc & ~flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_acc) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (pop) begin
                rp_d = rp_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_acc) - CNT_W'(pop);
            if (push_req && !push_acc) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wp_q]   <= if_pc;
            inst_mem[wp_q] <= if_inst;
        end
    end

    assign id_valid = (cnt_q != '0);
    assign id_pc    = id_valid ? pc_mem[rp_q]   : 32'd0;
    assign id_inst  = id_valid ? inst_mem[rp_q] : 32'd0;
    assign fq_full  = (cnt_q == CNT_W'(DEPTH));
    assign fq_count = cnt_q;
    assign fq_ovf   = ovf_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_inst;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic             fq_full;
    logic [CNT_W-1:0] fq_count;
    logic             fq_ovf;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];
    bit          m_ovf = 0;

    if_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .fq_full  (fq_full),
        .fq_count (fq_count),
        .fq_ovf   (fq_ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of accepted pushes.
    always @(posedge clk) begin
        if (rst) begin
            if (flush) begin
                m_pc.delete();
                m_inst.delete();
            end else begin
                int  sz;
                bit  pop_now;
                bit  push_now;
                sz       = m_pc.size();
                pop_now  = (sz != 0) && !stall[2];
                push_now = if_valid && !stall[1];
                if (pop_now) begin
                    void'(m_pc.pop_front());
                    void'(m_inst.pop_front());
                end
                if (push_now) begin
                    if (sz < DEPTH || pop_now) begin
                        m_pc.push_back(if_pc);
                        m_inst.push_back(if_inst);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    always @(negedge rst) begin
        m_pc.delete();
        m_inst.delete();
        m_ovf = 0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] epc;
            logic [31:0] einst;
            int          sz;
            sz    = m_pc.size();
            epc   = (sz != 0) ? m_pc[0]   : 32'd0;
            einst = (sz != 0) ? m_inst[0] : 32'd0;
            check("model_id_valid", {31'd0, id_valid}, {31'd0, sz != 0});
            check("model_id_pc",    id_pc,   epc);
            check("model_id_inst",  id_inst, einst);
            check("model_fq_full",  {31'd0, fq_full}, {31'd0, sz == DEPTH});
            check("model_fq_count", {29'd0, fq_count}, sz);
            check("model_fq_ovf",   {31'd0, fq_ovf}, {31'd0, m_ovf});
        end
    end

    task automatic step(input logic [5:0] st, input logic fl, input logic v, input logic [31:0] pc);
        stall    = st;
        flush    = fl;
        if_valid = v;
        if_pc    = pc;
        if_inst  = ~pc;
        @(posedge clk);
        #1;
        $display("txn t=%0t stall=%b flush=%b v=%b pc=%h -> valid=%b id_pc=%h cnt=%0d full=%b ovf=%b",
                 $time, st, fl, v, pc, id_valid, id_pc, fq_count, fq_full, fq_ovf);
    endtask

    initial begin
        stall = '0; flush = 0; if_valid = 0; if_pc = '0; if_inst = '0;
        rst = 1;
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        @(posedge clk);
        #1;
        cmp_en = 1;
        check("reset_id_valid", {31'd0, id_valid}, 32'd0);
        check("reset_id_pc", id_pc, 32'd0);
        check("reset_fq_count", {29'd0, fq_count}, 32'd0);
        check("reset_fq_ovf", {31'd0, fq_ovf}, 32'd0);

        // Fill with ID stalled
        for (int i = 0; i < 4; i++) begin
            step(6'b000100, 0, 1, 32'(i * 4));
            check("fill_count", {29'd0, fq_count}, 32'(i + 1));
        end
        check("fill_full", {31'd0, fq_full}, 32'd1);
        check("fill_head", id_pc, 32'h0);

        // Drain
        step(6'b0, 0, 0, 0);
        check("drain_pc1", id_pc, 32'h4);
        check("drain_inst1", id_inst, ~32'h4);
        step(6'b0, 0, 0, 0);
        check("drain_pc2", id_pc, 32'h8);
        step(6'b0, 0, 0, 0);
        check("drain_pc3", id_pc, 32'hC);
        step(6'b0, 0, 0, 0);
        check("drain_empty", {31'd0, id_valid}, 32'd0);

        // Streaming through the pointer wrap
        for (int k = 0; k < 12; k++) begin
            step(6'b0, 0, 1, 32'h100 + 32'(k * 4));
            check("wrap_pc", id_pc, 32'h100 + 32'(k * 4));
            check("wrap_count", {29'd0, fq_count}, 32'd1);
        end
        check("wrap_ovf", {31'd0, fq_ovf}, 32'd0);
        step(6'b0, 0, 0, 0);
        check("wrap_empty", {29'd0, fq_count}, 32'd0);

        // Refill, then push while popping at full
        for (int i = 0; i < 4; i++) step(6'b000100, 0, 1, 32'(i * 4));
        step(6'b0, 0, 1, 32'h10);
        check("fullpp_count", {29'd0, fq_count}, 32'd4);
        check("fullpp_head", id_pc, 32'h4);

        // Overflow: full and ID stalled
        step(6'b000100, 0, 1, 32'h20);
        check("ovf_flag", {31'd0, fq_ovf}, 32'd1);
        check("ovf_count", {29'd0, fq_count}, 32'd4);
        check("ovf_head", id_pc, 32'h4);
        step(6'b0, 0, 0, 0);
        check("ovf_drain1", id_pc, 32'h8);
        step(6'b0, 0, 0, 0);
        check("ovf_drain2", id_pc, 32'hC);
        step(6'b0, 0, 0, 0);
        check("ovf_drain3", id_pc, 32'h10);
        step(6'b0, 0, 0, 0);
        check("ovf_drain_empty", {31'd0, id_valid}, 32'd0);

        // Flush with 3 entries plus a same-cycle push
        for (int i = 0; i < 3; i++) step(6'b000100, 0, 1, 32'h200 + 32'(i * 4));
        check("pre_flush_count", {29'd0, fq_count}, 32'd3);
        step(6'b0, 1, 1, 32'h40);
        check("flush_count", {29'd0, fq_count}, 32'd0);
        check("flush_valid", {31'd0, id_valid}, 32'd0);
        check("flush_pc", id_pc, 32'd0);
        step(6'b000100, 0, 1, 32'h80);
        check("post_flush_pc", id_pc, 32'h80);
        check("post_flush_count", {29'd0, fq_count}, 32'd1);
        check("sticky_ovf", {31'd0, fq_ovf}, 32'd1);

        // Asynchronous reset between edges with 2 entries
        step(6'b000100, 0, 0, 0);
        stall = 6'b000100; if_valid = 1; if_pc = 32'h84; if_inst = ~32'h84;
        @(posedge clk);
        #1;
        if_valid = 0;
        check("pre_rst_count", {29'd0, fq_count}, 32'd2);
        #2 rst = 0;
        #1;
        check("arst_valid", {31'd0, id_valid}, 32'd0);
        check("arst_count", {29'd0, fq_count}, 32'd0);
        check("arst_ovf", {31'd0, fq_ovf}, 32'd0);
        rst = 1;
        step(6'b0, 0, 1, 32'h300);
        check("after_rst_pc", id_pc, 32'h300);
        step(6'b0, 0, 0, 0);
        step(6'b0, 0, 0, 0);

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
